// File: rtl/switch_nport_core_if.sv
// Per-port ingress and egress bundle of the N-port switch core.
// Fields of port p sit at [p*W +: W] in each packed vector.
interface switch_nport_core_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8
);
    logic [NUM_PORTS-1:0]        valid_in;
    logic [NUM_PORTS*ADDR_W-1:0] source_in;
    logic [NUM_PORTS*ADDR_W-1:0] target_in;
    logic [NUM_PORTS*DATA_W-1:0] data_in;
    logic [NUM_PORTS-1:0]        ready_in;
    logic [NUM_PORTS-1:0]        valid_out;
    logic [NUM_PORTS*ADDR_W-1:0] source_out;
    logic [NUM_PORTS*ADDR_W-1:0] target_out;
    logic [NUM_PORTS*DATA_W-1:0] data_out;
    logic [NUM_PORTS-1:0]        ready_out;

    modport slave (
        input  valid_in, source_in, target_in, data_in, ready_out,
        output ready_in, valid_out, source_out, target_out, data_out
    );

    modport master (
        output valid_in, source_in, target_in, data_in, ready_out,
        input  ready_in, valid_out, source_out, target_out, data_out
    );
endinterface

// File: rtl/switch_nport_core.sv
// N-port packet switch: per-input FIFO, per-output round-robin arbiter and
// a registered ready/valid output slot. Out-of-range targets are dropped and counted.
module switch_nport_core #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    switch_nport_core_if.slave  bus,
    output logic [15:0]         drop_count
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] tgt;
        logic [DATA_W-1:0] data;
    } pkt_t;

    pkt_t                 mem_q  [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]        wr_q   [NUM_PORTS];
    logic [AW-1:0]        rd_q   [NUM_PORTS];
    logic [AW:0]          cnt_q  [NUM_PORTS];
    pkt_t                 in_pkt [NUM_PORTS];
    pkt_t                 head   [NUM_PORTS];
    logic [NUM_PORTS-1:0] full, empty, rdy, push, drop, pop;
    logic [NUM_PORTS-1:0] req    [NUM_PORTS];
    logic [PW:0]          pick   [NUM_PORTS];
    logic [PW-1:0]        gnt    [NUM_PORTS];
    logic [PW-1:0]        ptr_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_v, load;
    pkt_t                 slot_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] valid_q;
    logic [15:0]          drop_q, drop_d;
    logic [16:0]          drop_sum;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                            input logic [PW-1:0] p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_PORTS;
            if (r[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        assign in_pkt[i] = {bus.source_in[i*ADDR_W +: ADDR_W],
                            bus.target_in[i*ADDR_W +: ADDR_W],
                            bus.data_in[i*DATA_W +: DATA_W]};
        assign full[i]   = (cnt_q[i] == (AW+1)'(FIFO_DEPTH));
        assign empty[i]  = (cnt_q[i] == '0);
        assign head[i]   = mem_q[i][rd_q[i]];
        assign rdy[i]    = ~full[i] & ~rst;
        assign push[i]   = bus.valid_in[i] & rdy[i] & (32'(in_pkt[i].tgt) < NUM_PORTS);
        assign drop[i]   = bus.valid_in[i] & rdy[i] & (32'(in_pkt[i].tgt) >= NUM_PORTS);
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = ~empty[i] && (head[i].tgt == ADDR_W'(o));
            end
        end
    end

    // Each head names one output, so at most one grant can pop a given FIFO.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            load[o]  = ~valid_q[o] | bus.ready_out[o];
            pick[o]  = rr_pick(req[o], ptr_q[o]);
            gnt_v[o] = pick[o][PW] & load[o];
            gnt[o]   = pick[o][PW-1:0];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt_v[o] && gnt[o] == PW'(i)) pop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 17'(drop[i]);
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) mem_q[i][wr_q[i]] <= in_pkt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_q[i]   <= '0;
                rd_q[i]   <= '0;
                cnt_q[i]  <= '0;
                ptr_q[i]  <= '0;
                slot_q[i] <= '0;
            end
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
                if (pop[i])  rd_q[i] <= rd_q[i] + 1'b1;
                cnt_q[i] <= cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (load[o]) begin
                    valid_q[o] <= gnt_v[o];
                    if (gnt_v[o]) begin
                        slot_q[o] <= head[gnt[o]];
                        ptr_q[o]  <= PW'((int'(gnt[o]) + 1) % NUM_PORTS);
                    end
                end
            end
            drop_q <= drop_d;
        end
    end

    assign bus.ready_in  = rdy;
    assign bus.valid_out = valid_q;
    assign drop_count    = drop_q;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        assign bus.source_out[o*ADDR_W +: ADDR_W] = slot_q[o].src;
        assign bus.target_out[o*ADDR_W +: ADDR_W] = slot_q[o].tgt;
        assign bus.data_out[o*DATA_W +: DATA_W]   = slot_q[o].data;
    end
endmodule

// File: tb/tb_switch_nport_core.sv
// Scoreboard bench for switch_nport_core: directed packets, per-output expected queues,
// and a negedge monitor that checks every presented output against its queue head.
module tb_switch_nport_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drop_count;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [4][$];

    switch_nport_core_if #(.NUM_PORTS(4), .ADDR_W(4), .DATA_W(8)) bus ();

    switch_nport_core #(.NUM_PORTS(4), .ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
        bus.valid_in[p]          = 1'b1;
        bus.source_in[p*4 +: 4]  = s;
        bus.target_in[p*4 +: 4]  = t;
        bus.data_in[p*8 +: 8]    = d;
    endtask

    task automatic expect_pkt(input int o, input logic [3:0] s, input logic [7:0] d);
        exp_q[o].push_back({s, 4'(o), d});
    endtask

    task automatic flush_exp();
        for (int o = 0; o < 4; o++) exp_q[o].delete();
    endtask

    // Monitor: a delivery pops the queue, a held slot must equal the queue head.
    always @(negedge clk) begin
        logic [15:0] got, exp;
        if (!rst) begin
            for (int o = 0; o < 4; o++) begin
                if (bus.valid_out[o]) begin
                    got = {bus.source_out[o*4 +: 4], bus.target_out[o*4 +: 4], bus.data_out[o*8 +: 8]};
                    if (exp_q[o].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out%0d: got %0h expected no packet", o, got);
                    end else begin
                        exp = bus.ready_out[o] ? exp_q[o].pop_front() : exp_q[o][0];
                        check($sformatf("out%0d", o), 32'(got), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cyc;
        logic rd;
        rst           = 1'b1;
        bus.valid_in  = '0;
        bus.source_in = '0;
        bus.target_in = '0;
        bus.data_in   = '0;
        bus.ready_out = 4'hF;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready_in", 32'(bus.ready_in), 32'h0);
        check("rst_valid_out", 32'(bus.valid_out), 32'h0);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_fields", 32'({bus.source_out, bus.target_out}), 32'h0);
        check("rst_drop", 32'(drop_count), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.ready_in), 32'hF);
        step();

        // Single delivery, 2-edge latency, one-cycle pulse
        set_port(0, 4'd0, 4'd2, 8'hA5);
        expect_pkt(2, 4'd0, 8'hA5);
        step();
        bus.valid_in = '0;
        @(posedge clk);
        @(negedge clk);
        check("latency_valid", 32'(bus.valid_out), 32'h4);
        @(negedge clk);
        check("pulse_valid", 32'(bus.valid_out), 32'h0);
        step();

        // Round robin on output 1
        set_port(0, 4'd0, 4'd1, 8'h10);
        set_port(1, 4'd1, 4'd1, 8'h11);
        set_port(3, 4'd3, 4'd1, 8'h13);
        expect_pkt(1, 4'd0, 8'h10);
        expect_pkt(1, 4'd1, 8'h11);
        expect_pkt(1, 4'd3, 8'h13);
        step();
        bus.valid_in = '0;
        repeat (6) step();
        set_port(1, 4'd1, 4'd1, 8'h21);
        set_port(3, 4'd3, 4'd1, 8'h23);
        expect_pkt(1, 4'd1, 8'h21);
        expect_pkt(1, 4'd3, 8'h23);
        step();
        bus.valid_in = '0;
        repeat (5) step();
        set_port(2, 4'd2, 4'd1, 8'h32);
        expect_pkt(1, 4'd2, 8'h32);
        step();
        bus.valid_in = '0;
        repeat (4) step();
        // pointer now 3: port 3 wins over port 0
        set_port(0, 4'd0, 4'd1, 8'h40);
        set_port(3, 4'd3, 4'd1, 8'h43);
        expect_pkt(1, 4'd3, 8'h43);
        expect_pkt(1, 4'd0, 8'h40);
        step();
        bus.valid_in = '0;
        repeat (5) step();
        check("rr_drained", 32'(exp_q[1].size()), 32'h0);

        // Backpressure on output 2
        bus.ready_out[2] = 1'b0;
        for (int j = 0; j < 8; j++) expect_pkt(2, 4'd1, 8'(j));
        k = 0;
        cyc = 0;
        set_port(1, 4'd1, 4'd2, 8'd0);
        while (cyc < 12) begin
            @(negedge clk);
            rd = bus.ready_in[1];
            step();
            cyc++;
            if (rd) begin
                k++;
                if (k < 8) set_port(1, 4'd1, 4'd2, 8'(k));
            end
        end
        check("bp_accepted", 32'(k), 32'd5);
        @(negedge clk);
        check("bp_ready_low", 32'(bus.ready_in[1]), 32'h0);
        check("bp_held_valid", 32'(bus.valid_out), 32'h4);
        step();
        bus.ready_out[2] = 1'b1;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            @(negedge clk);
            rd = bus.ready_in[1];
            step();
            cyc++;
            if (rd) begin
                k++;
                if (k < 8) set_port(1, 4'd1, 4'd2, 8'(k));
            end
        end
        bus.valid_in = '0;
        check("bp_all_accepted", 32'(k), 32'd8);
        repeat (10) step();
        check("bp_drained", 32'(exp_q[2].size()), 32'h0);

        // Drop and saturation
        set_port(2, 4'd2, 4'd7, 8'h99);
        step();
        bus.valid_in = '0;
        @(posedge clk);
        @(negedge clk);
        check("drop_no_valid", 32'(bus.valid_out), 32'h0);
        check("drop_count_1", 32'(drop_count), 32'd1);
        step();
        for (int p = 0; p < 4; p++) set_port(p, 4'(p), 4'hF, 8'h00);
        repeat (16383) step();
        bus.valid_in = '0;
        @(negedge clk);
        check("drop_count_bulk", 32'(drop_count), 32'd65533);
        step();
        set_port(0, 4'd0, 4'hF, 8'h00);
        repeat (2) step();
        bus.valid_in = '0;
        @(negedge clk);
        check("drop_count_max", 32'(drop_count), 32'hFFFF);
        step();
        for (int p = 0; p < 4; p++) set_port(p, 4'(p), 4'hE, 8'h00);
        step();
        bus.valid_in = '0;
        @(negedge clk);
        check("drop_count_sat", 32'(drop_count), 32'hFFFF);
        step();

        // Parallel outputs
        set_port(0, 4'd0, 4'd1, 8'h31);
        set_port(1, 4'd1, 4'd0, 8'h42);
        expect_pkt(1, 4'd0, 8'h31);
        expect_pkt(0, 4'd1, 8'h42);
        step();
        bus.valid_in = '0;
        @(posedge clk);
        @(negedge clk);
        check("parallel_valid", 32'(bus.valid_out), 32'h3);
        step();
        repeat (3) step();

        // Reset mid-flight: output 0 held, two more buffered (ptr[0]=2 -> port 2 first)
        bus.ready_out[0] = 1'b0;
        set_port(1, 4'd1, 4'd0, 8'h51);
        set_port(2, 4'd2, 4'd0, 8'h52);
        set_port(3, 4'd3, 4'd0, 8'h53);
        expect_pkt(0, 4'd2, 8'h52);
        expect_pkt(0, 4'd3, 8'h53);
        expect_pkt(0, 4'd1, 8'h51);
        step();
        bus.valid_in = '0;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_in", 32'(bus.ready_in), 32'h0);
        step();
        rst = 1'b0;
        flush_exp();
        bus.ready_out = 4'hF;
        @(negedge clk);
        check("midrst_valid", 32'(bus.valid_out), 32'h0);
        check("midrst_ready_after", 32'(bus.ready_in), 32'hF);
        check("midrst_drop", 32'(drop_count), 32'h0);
        step();
        repeat (8) step();
        // pointers back at 0: port 1 before port 3
        set_port(1, 4'd1, 4'd0, 8'h61);
        set_port(3, 4'd3, 4'd0, 8'h63);
        expect_pkt(0, 4'd1, 8'h61);
        expect_pkt(0, 4'd3, 8'h63);
        step();
        bus.valid_in = '0;
        repeat (6) step();

        for (int o = 0; o < 4; o++) check($sformatf("final_empty%0d", o), 32'(exp_q[o].size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
